uart_cmd_ctrl: RTL and testbench

- Command controller directly downstream of the UART receiver. It consumes received bytes (`RX_P_DATA` / `RX_D_VLD`) and decodes multi-byte command frames.
- It drives register-file write/read and ALU operations, then returns results as bytes to the UART transmitter through a valid/busy handshake.
- It is the single sequencing point between the serial link and the on-chip compute resources.

---
 rtl/uart_cmd_pkg.sv | 45 ++++
 rtl/uart_cmd_ctrl_if.sv | 37 +++
 rtl/uart_cmd_tx_seq.sv | 87 ++++++++
 rtl/uart_cmd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller: widths, command
// codes, FSM state encodings and the TX request payload.
package uart_cmd_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned FUN_WIDTH  = 4;

    localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA;
    localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB;
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [DATA_WIDTH-1:0] ERR_BYTE    = 8'hEE;

    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = 4'd0;
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OPA,
        ST_OPB,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_SET,
        TX_WAIT_CLR
    } tx_state_e;

    // Response handed from the command FSM to the TX sequencer; lo goes out first.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] hi;
        logic [DATA_WIDTH-1:0] lo;
        logic [1:0]            cnt;
    } tx_req_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the command controller (master) and the UART, register
// file and ALU (slave side).
interface uart_cmd_ctrl_if;
    import uart_cmd_pkg::*;

    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic                    RF_WrEn;
    logic                    RF_RdEn;
    logic [ADDR_WIDTH-1:0]   RF_Address;
    logic [DATA_WIDTH-1:0]   RF_WrData;
    logic [DATA_WIDTH-1:0]   RF_RdData;
    logic                    RF_RdData_Valid;
    logic                    ALU_EN;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_Valid;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    TX_busy;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid,
               ALU_OUT, ALU_OUT_Valid, TX_busy,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
               CLK_GATE_EN, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid,
               ALU_OUT, ALU_OUT_Valid, TX_busy,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
               CLK_GATE_EN, TX_P_DATA, TX_D_VLD
    );

endinterface

// File: rtl/uart_cmd_tx_seq.sv
// TX byte sequencer: sends one or two bytes (low first) over the valid/busy
// handshake, holding each byte until busy has been seen high and then low.
module uart_cmd_tx_seq
    import uart_cmd_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  tx_req_t               req,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_vld,
    output logic                  done
);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  vld_q, vld_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    data_d  = req.lo;
                    hi_d    = req.hi;
                    cnt_d   = req.cnt;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    vld_d   = 1'b1;
                    state_d = TX_WAIT_SET;
                end
            end
            TX_WAIT_SET: begin
                if (tx_busy) state_d = TX_WAIT_CLR;
            end
            TX_WAIT_CLR: begin
                // Byte is finished only once busy drops; then load the high byte or finish.
                if (!tx_busy) begin
                    if (cnt_q == 2'd2) begin
                        data_d  = hi_q;
                        cnt_d   = 2'd1;
                        state_d = TX_SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= TX_IDLE;
            data_q  <= '0;
            hi_q    <= '0;
            cnt_q   <= 2'd0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign tx_data = data_q;
    assign tx_vld  = vld_q;
    assign done    = done_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes RX command frames into RF/ALU operations and
// returns results through the TX sequencer. Define CMD_ILLEGAL_RESP_EN to answer
// unknown command bytes with 0xEE.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    uart_cmd_ctrl_if.master bus
);

    ctrl_state_e           state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic                  gate_q, gate_d;
    logic                  tx_start_q, tx_start_d;
    tx_req_t               tx_req_q, tx_req_d;
    logic                  tx_done;

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        alu_en_d   = 1'b0;
        fun_d      = fun_q;
        tx_start_d = 1'b0;
        tx_req_d   = tx_req_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        CMD_RF_WR:   state_d = ST_WR_ADDR;
                        CMD_RF_RD:   state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_OPA;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN;
                        default: begin
`ifdef CMD_ILLEGAL_RESP_EN
                            tx_start_d   = 1'b1;
                            tx_req_d.hi  = '0;
                            tx_req_d.lo  = ERR_BYTE;
                            tx_req_d.cnt = 2'd1;
                            state_d      = ST_TX;
`endif
                        end
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    wdata_d = bus.RX_P_DATA;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    rd_en_d = 1'b1;
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.RF_RdData_Valid) begin
                    tx_start_d   = 1'b1;
                    tx_req_d.hi  = '0;
                    tx_req_d.lo  = bus.RF_RdData;
                    tx_req_d.cnt = 2'd1;
                    state_d      = ST_TX;
                end
            end
            ST_OPA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    addr_d  = OPA_ADDR;
                    wdata_d = bus.RX_P_DATA;
                    state_d = ST_OPB;
                end
            end
            ST_OPB: begin
                if (bus.RX_D_VLD) begin
                    wr_en_d = 1'b1;
                    addr_d  = OPB_ADDR;
                    wdata_d = bus.RX_P_DATA;
                    state_d = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_en_d = 1'b1;
                    fun_d    = bus.RX_P_DATA[FUN_WIDTH-1:0];
                    state_d  = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (bus.ALU_OUT_Valid) begin
                    tx_start_d   = 1'b1;
                    tx_req_d.hi  = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_req_d.lo  = bus.ALU_OUT[DATA_WIDTH-1:0];
                    tx_req_d.cnt = 2'd2;
                    state_d      = ST_TX;
                end
            end
            ST_TX: begin
                if (tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Gate tracks the registered state, so it spans exactly ALU_FUN..ALU_WAIT.
        gate_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            alu_en_q   <= 1'b0;
            fun_q      <= '0;
            gate_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_req_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            alu_en_q   <= alu_en_d;
            fun_q      <= fun_d;
            gate_q     <= gate_d;
            tx_start_q <= tx_start_d;
            tx_req_q   <= tx_req_d;
        end
    end

    assign bus.RF_WrEn     = wr_en_q;
    assign bus.RF_RdEn     = rd_en_q;
    assign bus.RF_Address  = addr_q;
    assign bus.RF_WrData   = wdata_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = fun_q;
    assign bus.CLK_GATE_EN = gate_q;

    uart_cmd_tx_seq u_tx_seq (
        .CLK     (CLK),
        .RST     (RST),
        .start   (tx_start_q),
        .req     (tx_req_q),
        .tx_busy (bus.TX_busy),
        .tx_data (bus.TX_P_DATA),
        .tx_vld  (bus.TX_D_VLD),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with small RF, ALU and UART-transmitter models.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

`ifdef CMD_ILLEGAL_RESP_EN
    localparam int ILL_N = 1;
`else
    localparam int ILL_N = 0;
`endif

    typedef struct {
        logic [31:0] b;
        int          n;
        int          ew;
        logic [3:0]  wa;
        logic [7:0]  wd;
        int          er;
        logic [3:0]  ra;
        int          ea;
        logic [3:0]  fn;
        int          et;
        logic [7:0]  x0;
        logic [7:0]  x1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();
    uart_cmd_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int rd_lat = 2;
    int alu_lat = 3;
    logic hold_busy = 1'b0;
    logic tx_busy_m;
    logic [7:0] mem [16] = '{default: 8'h00};
    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, both_cnt = 0, stab_err = 0;
    logic [3:0] last_waddr = 4'h0, last_raddr = 4'h0, last_fun = 4'h0;
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] tx_log [$];

    assign bus.TX_busy = tx_busy_m | hold_busy;

    // Register-file write model and strobe bookkeeping
    always @(posedge clk) begin
        #1;
        if (bus.RF_WrEn) begin
            wr_cnt++;
            last_waddr = bus.RF_Address;
            last_wdata = bus.RF_WrData;
            mem[bus.RF_Address] = bus.RF_WrData;
        end
        if (bus.RF_RdEn) begin
            rd_cnt++;
            last_raddr = bus.RF_Address;
        end
        if (bus.RF_WrEn && bus.RF_RdEn) both_cnt++;
        if (bus.ALU_EN) begin
            alu_cnt++;
            last_fun = bus.ALU_FUN;
        end
    end

    always @(negedge clk)
        if (tx_busy_m && tx_log.size() > 0 && bus.TX_P_DATA !== tx_log[$]) stab_err++;

    initial begin
        logic [3:0] ra;
        bus.RF_RdData = 8'h00;
        bus.RF_RdData_Valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.RF_RdEn) begin
                ra = bus.RF_Address;
                for (int i = 0; i < rd_lat; i++) begin @(posedge clk); #1; end
                bus.RF_RdData = mem[ra];
                bus.RF_RdData_Valid = 1'b1;
                @(posedge clk); #1;
                bus.RF_RdData_Valid = 1'b0;
            end
        end
    end

    // ALU model: 0 add, 1 subtract, 2 multiply on RF[0], RF[1]
    initial begin
        logic [7:0] oa, ob;
        logic [3:0] f;
        logic [15:0] r;
        bus.ALU_OUT = 16'h0000;
        bus.ALU_OUT_Valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.ALU_EN) begin
                oa = mem[0]; ob = mem[1]; f = bus.ALU_FUN;
                case (f)
                    4'd0:    r = 16'(oa) + 16'(ob);
                    4'd1:    r = 16'(oa) - 16'(ob);
                    4'd2:    r = 16'(oa) * 16'(ob);
                    default: r = 16'h0000;
                endcase
                for (int i = 0; i < alu_lat; i++) begin @(posedge clk); #1; end
                bus.ALU_OUT = r;
                bus.ALU_OUT_Valid = 1'b1;
                @(posedge clk); #1;
                bus.ALU_OUT_Valid = 1'b0;
            end
        end
    end

    // UART transmitter model: busy for 10 cycles after each accepted byte
    initial begin
        tx_busy_m = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.TX_D_VLD) begin
                tx_log.push_back(bus.TX_P_DATA);
                tx_busy_m = 1'b1;
                repeat (10) begin @(posedge clk); #1; end
                tx_busy_m = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD = 1'b1;
        @(posedge clk); #1;
        bus.RX_D_VLD = 1'b0;
        idle(3);
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int n,
                                input int ew, input logic [3:0] wa, input logic [7:0] wd,
                                input int er, input logic [3:0] ra,
                                input int ea, input logic [3:0] fn,
                                input int et, input logic [7:0] x0, input logic [7:0] x1);
        vec_t v;
        v.b = b; v.n = n; v.ew = ew; v.wa = wa; v.wd = wd; v.er = er; v.ra = ra;
        v.ea = ea; v.fn = fn; v.et = et; v.x0 = x0; v.x1 = x1;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"},  32'(bus.RF_WrEn), 32'd0);
        check({tag, "_rden"},  32'(bus.RF_RdEn), 32'd0);
        check({tag, "_addr"},  32'(bus.RF_Address), 32'd0);
        check({tag, "_wdata"}, 32'(bus.RF_WrData), 32'd0);
        check({tag, "_aluen"}, 32'(bus.ALU_EN), 32'd0);
        check({tag, "_fun"},   32'(bus.ALU_FUN), 32'd0);
        check({tag, "_gate"},  32'(bus.CLK_GATE_EN), 32'd0);
        check({tag, "_txvld"}, 32'(bus.TX_D_VLD), 32'd0);
        check({tag, "_txdat"}, 32'(bus.TX_P_DATA), 32'd0);
    endtask

    initial begin
        vec_t v [10];
        int w0, r0, a0, t0;

        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD = 1'b0;

        v[0] = mk(32'hAA053C00, 3, 1, 4'h5, 8'h3C, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        v[1] = mk(32'hBB050000, 2, 0, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
        v[2] = mk(32'hCC123400, 4, 2, 4'h1, 8'h34, 0, 4'h0, 1, 4'h0, 2, 8'h46, 8'h00);
        v[3] = mk(32'hDD020000, 2, 0, 4'h0, 8'h00, 0, 4'h0, 1, 4'h2, 2, 8'hA8, 8'h03);
        v[4] = mk(32'h77000000, 1, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, ILL_N, 8'hEE, 8'h00);
        v[5] = mk(32'hAA0FFF00, 3, 1, 4'hF, 8'hFF, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        v[6] = mk(32'hBB0F0000, 2, 0, 4'h0, 8'h00, 1, 4'hF, 0, 4'h0, 1, 8'hFF, 8'h00);
        v[7] = mk(32'hCCFFFF02, 4, 2, 4'h1, 8'hFF, 0, 4'h0, 1, 4'h2, 2, 8'h01, 8'hFE);
        v[8] = mk(32'hAA1A5500, 3, 1, 4'hA, 8'h55, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        v[9] = mk(32'hCC102031, 4, 2, 4'h1, 8'h20, 0, 4'h0, 1, 4'h1, 2, 8'hF0, 8'hFF);

        idle(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            w0 = wr_cnt; r0 = rd_cnt; a0 = alu_cnt; t0 = tx_log.size();
            for (int k = 0; k < v[i].n; k++) send_byte(v[i].b[31-8*k -: 8]);
            idle(60);
            check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(v[i].ew));
            if (v[i].ew > 0) begin
                check($sformatf("v%0d_wr_addr", i), 32'(last_waddr), 32'(v[i].wa));
                check($sformatf("v%0d_wr_data", i), 32'(last_wdata), 32'(v[i].wd));
            end
            check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - r0), 32'(v[i].er));
            if (v[i].er > 0) check($sformatf("v%0d_rd_addr", i), 32'(last_raddr), 32'(v[i].ra));
            check($sformatf("v%0d_alu_cnt", i), 32'(alu_cnt - a0), 32'(v[i].ea));
            if (v[i].ea > 0) check($sformatf("v%0d_alu_fun", i), 32'(last_fun), 32'(v[i].fn));
            check($sformatf("v%0d_tx_cnt", i), 32'(tx_log.size() - t0), 32'(v[i].et));
            if (v[i].et > 0 && tx_log.size() > t0)
                check($sformatf("v%0d_tx0", i), 32'(tx_log[t0]), 32'(v[i].x0));
            if (v[i].et > 1 && tx_log.size() > t0 + 1)
                check($sformatf("v%0d_tx1", i), 32'(tx_log[t0+1]), 32'(v[i].x1));
        end

        // Read response stalled by TX_busy; command bytes arriving meanwhile are dropped
        hold_busy = 1'b1;
        t0 = tx_log.size(); a0 = alu_cnt;
        send_byte(8'hBB);
        send_byte(8'h05);
        idle(6);
        send_byte(8'hDD);
        send_byte(8'hDD);
        idle(28);
        check("hold_no_tx", 32'(tx_log.size() - t0), 32'd0);
        hold_busy = 1'b0;
        idle(40);
        check("hold_tx_cnt", 32'(tx_log.size() - t0), 32'd1);
        if (tx_log.size() > t0) check("hold_tx_data", 32'(tx_log[t0]), 32'h3C);
        check("hold_dd_dropped", 32'(alu_cnt - a0), 32'd0);
        check("hold_gate_off", 32'(bus.CLK_GATE_EN), 32'd0);

        // Result valid coincident with the wait-state entry cycle
        rd_lat = 0; alu_lat = 0;
        t0 = tx_log.size();
        send_byte(8'hBB);
        send_byte(8'h0A);
        idle(30);
        check("coinc_rd_cnt", 32'(tx_log.size() - t0), 32'd1);
        if (tx_log.size() > t0) check("coinc_rd_data", 32'(tx_log[t0]), 32'h55);
        t0 = tx_log.size();
        send_byte(8'hDD);
        check("gate_on_in_fun", 32'(bus.CLK_GATE_EN), 32'd1);
        send_byte(8'h00);
        idle(50);
        check("coinc_alu_cnt", 32'(tx_log.size() - t0), 32'd2);
        if (tx_log.size() > t0 + 1) begin
            check("coinc_alu_lo", 32'(tx_log[t0]), 32'h30);
            check("coinc_alu_hi", 32'(tx_log[t0+1]), 32'h00);
        end
        check("gate_off_after", 32'(bus.CLK_GATE_EN), 32'd0);
        rd_lat = 2; alu_lat = 3;

        // Reset mid-frame aborts the write; the next frame is handled normally
        w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        rst = 1'b0;
        idle(2);
        check_reset_outputs("midrst");
        rst = 1'b1;
        idle(20);
        check("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'h66);
        idle(20);
        check("postrst_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        check("postrst_wr_addr", 32'(last_waddr), 32'h7);
        check("postrst_wr_data", 32'(last_wdata), 32'h66);

        check("wr_rd_overlap", 32'(both_cnt), 32'd0);
        check("tx_data_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
